mc_array_ctrl: RTL and testbench

Sequencing controller for the 64x64 complementary-memristor compute array. It accepts row-granular write and read/compute requests over a valid/ready interface and generates the phased array drive: word lines (CWLE/CWLO), bit-line enables (CBLEN), bit/source lines (CBL/CSL) and the DIN/DINb operands. It captures the array's OR-combined DOUT and returns it on a valid/ready response channel. It sits between the core-side accelerator logic and the array macro.

---
 rtl/mc_array_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mc_array_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_array_ctrl.sv
// mc_array_ctrl: row-granular write and read/compute sequencer for the 64x64 complementary-memristor array.
// Latency: write resp at edge 2P+2 (4P+3 with MC_ARRAY_CTRL_VERIFY_EN read-back), read resp at edge 2P+1.
// Backpressure: one request in flight; req_ready_o only in IDLE, response held stable until resp_ready_i.
module mc_array_ctrl #(
    parameter int PULSE_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [5:0]  req_row_i,
    input  logic [63:0] req_mask_i,
    input  logic [63:0] req_data_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [63:0] resp_data_o,
    output logic        resp_err_o,
    output logic [31:0] mc_cwle_o,
    output logic [31:0] mc_cwlo_o,
    output logic [63:0] mc_cblen_o,
    output logic [63:0] mc_cbl_o,
    output logic [63:0] mc_csl_o,
    output logic [63:0] mc_din_o,
    output logic [63:0] mc_dinb_o,
    input  logic [63:0] mc_dout_i
);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_A, S_GAP1, S_WR_B, S_GAP2, S_CLR, S_ARM, S_EVAL, S_RESP
    } state_t;

    localparam logic [7:0] LP_LOAD = 8'(PULSE_CYCLES - 1);

    state_t      r_state, w_nxt;
    logic [7:0]  r_cnt;
    logic        r_req_rdy, r_resp_vld;
    logic [63:0] r_resp_data;
    logic        r_we;
    logic [5:0]  r_row;
    logic [63:0] r_mask, r_data;
    logic [31:0] r_cwle, r_cwlo, w_cwle, w_cwlo;
    logic [63:0] r_cblen, r_cbl, r_csl, r_din, r_dinb;
    logic [63:0] w_cblen, w_cbl, w_csl, w_din, w_dinb;
    logic        w_accept, w_done, w_idle, w_we;
    logic [5:0]  w_row;
    logic [63:0] w_mask, w_data, w_d_eval;
    logic [31:0] w_wl, w_wl_e, w_wl_o;

    assign w_accept = req_valid_i & r_req_rdy;
    assign w_done   = (r_cnt == 8'd0);
    assign w_idle   = (r_state == S_IDLE);

    // At the accept edge the request latch is not loaded yet, so drive straight from the inputs
    assign w_we     = w_idle ? req_we_i   : r_we;
    assign w_row    = w_idle ? req_row_i  : r_row;
    assign w_mask   = w_idle ? req_mask_i : r_mask;
    assign w_data   = w_idle ? req_data_i : r_data;
    // Read-back after a write evaluates with d = 0 so the array returns the stored bits
    assign w_d_eval = w_we ? 64'd0 : w_data;
    assign w_wl     = 32'd1 << w_row[5:1];
    assign w_wl_e   = w_row[0] ? w_wl : 32'd0;
    assign w_wl_o   = w_row[0] ? 32'd0 : w_wl;

    // Next-state sequencing and the array drive pattern of the state being entered
    always_comb begin
        w_nxt   = r_state;
        w_cwle  = 32'd0;
        w_cwlo  = 32'd0;
        w_cblen = 64'd0;
        w_cbl   = 64'd0;
        w_csl   = 64'd0;
        w_din   = 64'd0;
        w_dinb  = 64'd0;
        case (r_state)
            S_IDLE: if (w_accept) w_nxt = req_we_i ? S_WR_A : S_CLR;
            S_WR_A: if (w_done) w_nxt = S_GAP1;
            S_GAP1: w_nxt = S_WR_B;
            S_WR_B: if (w_done) w_nxt = S_GAP2;
`ifdef MC_ARRAY_CTRL_VERIFY_EN
            S_GAP2: w_nxt = S_CLR;
`else
            S_GAP2: w_nxt = S_RESP;
`endif
            S_CLR:  w_nxt = S_ARM;
            S_ARM:  if (w_done) w_nxt = S_EVAL;
            S_EVAL: if (w_done) w_nxt = S_RESP;
            S_RESP: if (resp_ready_i) w_nxt = S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
        case (w_nxt)
            S_WR_A: begin
                w_cwle = w_wl_e; w_cwlo = w_wl_o; w_cblen = w_mask;
                w_cbl  = ~w_data & w_mask;
                w_csl  = w_data & w_mask;
            end
            S_WR_B: begin
                w_cwle = w_wl_e; w_cwlo = w_wl_o; w_cblen = w_mask;
                w_cbl  = ~w_data & w_mask;
                w_csl  = ~w_data & w_mask;
            end
            S_CLR: w_csl = '1;
            S_ARM: begin
                w_cwle = w_wl_e; w_cwlo = w_wl_o; w_csl = '1;
            end
            S_EVAL: begin
                w_cwle = w_wl_e; w_cwlo = w_wl_o;
                w_din  = w_d_eval;
                w_dinb = ~w_d_eval;
            end
            default: ;
        endcase
    end

    // State register and phase counter, reloaded with P-1 on every state change
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_nxt;
            if (w_nxt != r_state) r_cnt <= LP_LOAD;
            else if (!w_done)     r_cnt <= r_cnt - 8'd1;
        end
    end

    // Request latch, held for the whole sequence
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_we <= 1'b0; r_row <= 6'd0; r_mask <= 64'd0; r_data <= 64'd0;
        end else if (w_accept) begin
            r_we <= req_we_i; r_row <= req_row_i; r_mask <= req_mask_i; r_data <= req_data_i;
        end
    end

    // Registered array drive; reset forces every line low immediately
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cwle <= 32'd0; r_cwlo <= 32'd0; r_cblen <= 64'd0;
            r_cbl  <= 64'd0; r_csl  <= 64'd0; r_din   <= 64'd0; r_dinb <= 64'd0;
        end else begin
            r_cwle <= w_cwle; r_cwlo <= w_cwlo; r_cblen <= w_cblen;
            r_cbl  <= w_cbl;  r_csl  <= w_csl;  r_din   <= w_din;  r_dinb <= w_dinb;
        end
    end

    // Handshake flags and response payload, captured on the final EVAL edge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_req_rdy   <= 1'b0;
            r_resp_vld  <= 1'b0;
            r_resp_data <= 64'd0;
        end else begin
            r_req_rdy  <= (w_nxt == S_IDLE);
            r_resp_vld <= (w_nxt == S_RESP);
            if (w_accept)                          r_resp_data <= 64'd0;
            else if (r_state == S_EVAL && w_done)  r_resp_data <= mc_dout_i;
        end
    end

`ifdef MC_ARRAY_CTRL_VERIFY_EN
    logic r_resp_err;
    // Verify flag: any masked column whose read-back differs (or is unknown) from the written data
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                             r_resp_err <= 1'b0;
        else if (w_accept)                     r_resp_err <= 1'b0;
        else if (r_state == S_EVAL && w_done)  r_resp_err <= r_we & (((mc_dout_i ^ r_data) & r_mask) !== 64'd0);
    end
    assign resp_err_o = r_resp_err;
`else
    assign resp_err_o = 1'b0;
`endif

    assign req_ready_o  = r_req_rdy;
    assign resp_valid_o = r_resp_vld;
    assign resp_data_o  = r_resp_data;
    assign mc_cwle_o    = r_cwle;
    assign mc_cwlo_o    = r_cwlo;
    assign mc_cblen_o   = r_cblen;
    assign mc_cbl_o     = r_cbl;
    assign mc_csl_o     = r_csl;
    assign mc_din_o     = r_din;
    assign mc_dinb_o    = r_dinb;

endmodule

// File: tb/tb_mc_array_ctrl.sv
// Directed bench for mc_array_ctrl: P=1 instance on a behavioural array model, P=4 instance for timing/reset.
module tb_mc_array_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

`ifdef MC_ARRAY_CTRL_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif
    localparam int WR_LAT1 = VER ? 7 : 4;
    localparam int RD_LAT1 = 3;
    localparam int WR_LAT4 = VER ? 19 : 10;
    localparam int RD_LAT4 = 9;

    // shared request inputs, steered to one instance by sel
    logic        sel = 1'b0;
    logic        req_valid = 1'b0, resp_ready = 1'b0, req_we = 1'b0;
    logic [5:0]  req_row = 6'd0;
    logic [63:0] req_mask = 64'd0, req_data = 64'd0;
    logic [5:0]  cur_row = 6'd0;
    logic [63:0] stuck_mask = 64'd0;

    logic        a_rdy, a_rvld, a_rerr, b_rdy, b_rvld, b_rerr;
    logic [63:0] a_rdata, b_rdata;
    logic [31:0] a_cwle, a_cwlo, b_cwle, b_cwlo;
    logic [63:0] a_cblen, a_cbl, a_csl, a_din, a_dinb, a_dout;
    logic [63:0] b_cblen, b_cbl, b_csl, b_din, b_dinb;

    mc_array_ctrl #(.PULSE_CYCLES(1)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid & ~sel), .req_ready_o(a_rdy), .req_we_i(req_we),
        .req_row_i(req_row), .req_mask_i(req_mask), .req_data_i(req_data),
        .resp_valid_o(a_rvld), .resp_ready_i(resp_ready & ~sel),
        .resp_data_o(a_rdata), .resp_err_o(a_rerr),
        .mc_cwle_o(a_cwle), .mc_cwlo_o(a_cwlo), .mc_cblen_o(a_cblen), .mc_cbl_o(a_cbl),
        .mc_csl_o(a_csl), .mc_din_o(a_din), .mc_dinb_o(a_dinb), .mc_dout_i(a_dout));

    mc_array_ctrl #(.PULSE_CYCLES(4)) dut4 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid & sel), .req_ready_o(b_rdy), .req_we_i(req_we),
        .req_row_i(req_row), .req_mask_i(req_mask), .req_data_i(req_data),
        .resp_valid_o(b_rvld), .resp_ready_i(resp_ready & sel),
        .resp_data_o(b_rdata), .resp_err_o(b_rerr),
        .mc_cwle_o(b_cwle), .mc_cwlo_o(b_cwlo), .mc_cblen_o(b_cblen), .mc_cbl_o(b_cbl),
        .mc_csl_o(b_csl), .mc_din_o(b_din), .mc_dinb_o(b_dinb), .mc_dout_i(64'd0));

    wire [383:0] a_drv = {a_cwle, a_cwlo, a_cblen, a_cbl, a_csl, a_din, a_dinb};
    wire [383:0] b_drv = {b_cwle, b_cwlo, b_cblen, b_cbl, b_csl, b_din, b_dinb};
    wire         m_rdy   = sel ? b_rdy   : a_rdy;
    wire         m_rvld  = sel ? b_rvld  : a_rvld;
    wire [63:0]  m_rdata = sel ? b_rdata : a_rdata;
    wire         m_rerr  = sel ? b_rerr  : a_rerr;
    wire [63:0]  m_wl    = sel ? {b_cwle, b_cwlo} : {a_cwle, a_cwlo};
    wire [63:0]  m_csl   = sel ? b_csl   : a_csl;
    wire [63:0]  m_cbl   = sel ? b_cbl   : a_cbl;
    wire [383:0] m_drv   = sel ? b_drv   : a_drv;

    // Array model: cbl!=csl programs m0 to csl, cbl==csl programs m1 to csl; read = m0 ^ din
    logic [63:0] m0 [64];
    logic [63:0] m1 [64];
    initial for (int r = 0; r < 64; r++) begin m0[r] = 64'd0; m1[r] = '1; end

    function automatic logic wl_on(input int r, input logic [31:0] e, input logic [31:0] o);
        return r[0] ? e[r >> 1] : o[r >> 1];
    endfunction

    always @(posedge clk) begin
        for (int r = 0; r < 64; r++)
            if (wl_on(r, a_cwle, a_cwlo))
                for (int c = 0; c < 64; c++)
                    if (a_cblen[c]) begin
                        if (a_cbl[c] != a_csl[c]) m0[r][c] <= a_csl[c];
                        else                      m1[r][c] <= a_csl[c];
                    end
    end

    always_comb begin
        a_dout = 64'd0;
        for (int r = 0; r < 64; r++)
            if (wl_on(r, a_cwle, a_cwlo) && a_cblen == 64'd0 && a_csl == 64'd0)
                a_dout = (m0[r] & ~stuck_mask) ^ a_din;
    end

    function automatic logic [63:0] wl_of(input logic [5:0] r);
        logic [31:0] w;
        w = 32'd1 << r[5:1];
        return r[0] ? {w, 32'd0} : {32'd0, w};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Word lines of the P=1 instance may only ever select the row in flight
    always @(negedge clk)
        if (!rst && !sel && {a_cwle, a_cwlo} != 64'd0)
            chk("wl_row", {a_cwle, a_cwlo}, wl_of(cur_row));

    // Returns at the negedge after the accept edge (edge 0)
    task automatic start_req(input logic we, input logic [5:0] row,
                             input logic [63:0] mask, input logic [63:0] data);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_row = row; req_mask = mask; req_data = data;
        cur_row = row;
        n = 0;
        while (!m_rdy && n < 50) begin @(negedge clk); n++; end
        chk("req_accept_bound", 64'(n < 50), 64'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_resp(input int k0, input int exp_lat, input string name);
        int k;
        k = k0;
        while (!m_rvld && k < 200) begin @(negedge clk); k++; end
        chk(name, 64'(k), 64'(exp_lat));
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        chk("hs_ready", 64'(m_rdy), 64'd1);
        chk("hs_valid_drop", 64'(m_rvld), 64'd0);
    endtask

    typedef struct {
        logic        we;
        logic [5:0]  row;
        logic [63:0] mask;
        logic [63:0] data;
        logic [63:0] exp_rd;  // read result, or row contents after a write
    } vec_t;
    vec_t tbl [13];

    logic [63:0] held;
    logic        seen;

    initial begin
        tbl[0]  = '{1'b1, 6'd5,  '1, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF};
        tbl[1]  = '{1'b0, 6'd5,  '1, 64'h0,                64'h0123456789ABCDEF};
        tbl[2]  = '{1'b1, 6'd8,  '1, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
        tbl[3]  = '{1'b1, 6'd8,  64'h00000000FFFFFFFF, 64'h0, 64'hFFFFFFFF00000000};
        tbl[4]  = '{1'b0, 6'd8,  '1, 64'h0,                64'hFFFFFFFF00000000};
        tbl[5]  = '{1'b1, 6'd8,  '1, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
        tbl[6]  = '{1'b0, 6'd8,  '1, 64'hFFFF0000FFFF0000, 64'h0000FFFF0000FFFF};
        tbl[7]  = '{1'b0, 6'd5,  '1, 64'hFFFFFFFFFFFFFFFF, 64'hFEDCBA9876543210};
        tbl[8]  = '{1'b1, 6'd0,  '1, 64'hA5A5A5A5A5A5A5A5, 64'hA5A5A5A5A5A5A5A5};
        tbl[9]  = '{1'b1, 6'd63, '1, 64'h5A5A5A5A5A5A5A5A, 64'h5A5A5A5A5A5A5A5A};
        tbl[10] = '{1'b0, 6'd0,  '1, 64'h0,                64'hA5A5A5A5A5A5A5A5};
        tbl[11] = '{1'b0, 6'd63, '1, 64'h0,                64'h5A5A5A5A5A5A5A5A};
        tbl[12] = '{1'b0, 6'd1,  '1, 64'h0,                64'h0};

        // Reset held for 3 cycles: everything low
        repeat (3) @(negedge clk);
        chk("rst_a_zero", 64'(|{a_rdy, a_rvld, a_rdata, a_rerr, a_drv}), 64'd0);
        chk("rst_b_zero", 64'(|{b_rdy, b_rvld, b_rdata, b_rerr, b_drv}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rel_ready", 64'(a_rdy & b_rdy), 64'd1);
        chk("rst_rel_wl", m_wl, 64'd0);

        // Write row 5, P=1: phase-by-phase drive
        start_req(1'b1, 6'd5, '1, 64'h0123456789ABCDEF);
        chk("wra_wl", m_wl, wl_of(6'd5));
        chk("wra_csl", m_csl, 64'h0123456789ABCDEF);
        chk("wra_cbl", m_cbl, ~64'h0123456789ABCDEF);
        chk("wra_cblen", a_cblen, '1);
        @(negedge clk);
        chk("gap1_zero", 64'(|m_drv), 64'd0);
        @(negedge clk);
        chk("wrb_wl", m_wl, wl_of(6'd5));
        chk("wrb_csl", m_csl, ~64'h0123456789ABCDEF);
        chk("wrb_cbl", m_cbl, ~64'h0123456789ABCDEF);
        @(negedge clk);
        chk("gap2_zero", 64'(|m_drv), 64'd0);
        wait_resp(3, WR_LAT1, "wr5_latency");
        chk("wr5_data", m_rdata, VER ? 64'h0123456789ABCDEF : 64'd0);
        handshake();

        // Table of transactions on the P=1 instance
        for (int i = 0; i < 13; i++) begin
            start_req(tbl[i].we, tbl[i].row, tbl[i].mask, tbl[i].data);
            wait_resp(0, tbl[i].we ? WR_LAT1 : RD_LAT1, $sformatf("v%0d_latency", i));
            chk($sformatf("v%0d_data", i), m_rdata, (tbl[i].we && !VER) ? 64'd0 : tbl[i].exp_rd);
            chk($sformatf("v%0d_err", i), 64'(m_rerr), 64'd0);
            handshake();
        end

        // Compute read on row 8 (all ones): CLR / ARM / EVAL drive
        start_req(1'b0, 6'd8, 64'd0, 64'hFFFF0000FFFF0000);
        chk("clr_wl", m_wl, 64'd0);
        chk("clr_csl", m_csl, '1);
        chk("clr_cblen", a_cblen, 64'd0);
        @(negedge clk);
        chk("arm_wl", m_wl, wl_of(6'd8));
        chk("arm_csl", m_csl, '1);
        @(negedge clk);
        chk("eval_csl", m_csl, 64'd0);
        chk("eval_din", a_din, 64'hFFFF0000FFFF0000);
        chk("eval_dinb", a_dinb, 64'h0000FFFF0000FFFF);
        wait_resp(2, RD_LAT1, "cmp_latency");
        chk("cmp_data", m_rdata, 64'h0000FFFF0000FFFF);
        handshake();

        // Backpressure: response held 10 cycles while another request waits
        start_req(1'b0, 6'd5, '1, 64'h0);
        wait_resp(0, RD_LAT1, "bp_latency");
        held = m_rdata;
        chk("bp_data", held, 64'h0123456789ABCDEF);
        req_valid = 1'b1; req_we = 1'b0; req_row = 6'd8; req_data = 64'h0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid_hold", 64'(m_rvld), 64'd1);
            chk("bp_data_hold", m_rdata, held);
            chk("bp_ready_low", 64'(m_rdy), 64'd0);
        end
        cur_row = 6'd8;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        chk("bp_ready_after_hs", 64'(m_rdy), 64'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_accepted", 64'(m_rdy), 64'd0);
        chk("bp_next_clr", m_csl, '1);
        wait_resp(0, RD_LAT1, "bp_next_latency");
        chk("bp_next_data", m_rdata, '1);
        handshake();

`ifdef MC_ARRAY_CTRL_VERIFY_EN
        // Stuck-at-0 column 7 must be flagged by the read-back
        stuck_mask = 64'h80;
        start_req(1'b1, 6'd10, '1, 64'h0000000000000080);
        wait_resp(0, WR_LAT1, "stuck_latency");
        chk("stuck_err", 64'(m_rerr), 64'd1);
        handshake();
        stuck_mask = 64'd0;
`endif

        // P=4 instance: latencies, then reset during WR_B
        sel = 1'b1;
        start_req(1'b1, 6'd3, '1, 64'h00FF00FF00FF00FF);
        wait_resp(0, WR_LAT4, "p4_wr_latency");
        handshake();
        start_req(1'b0, 6'd3, '1, 64'h0);
        wait_resp(0, RD_LAT4, "p4_rd_latency");
        handshake();
        start_req(1'b1, 6'd3, '1, 64'h00FF00FF00FF00FF);
        repeat (6) @(negedge clk);
        chk("p4_wrb_wl", m_wl, wl_of(6'd3));
        chk("p4_wrb_csl", m_csl, ~64'h00FF00FF00FF00FF);
        rst = 1'b1;
        #1;
        chk("p4_rst_drive", 64'(|m_drv), 64'd0);
        chk("p4_rst_valid", 64'(m_rvld), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_rvld || m_drv != 384'd0) seen = 1'b1;
        end
        chk("p4_no_resp_after_rst", 64'(seen), 64'd0);
        chk("p4_idle_ready", 64'(m_rdy), 64'd1);
        sel = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
